// File: rtl/tt_um_ziyi_yuchen.sv
// Four-channel 8-bit PWM tile with byte-wide register write port.
// Define PWM_SYNC_LOAD_EN to load active duty/top/presc only at period wrap.
module tt_um_ziyi_yuchen (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic [2:0]      stb_q;
  logic            we;
  logic [3:0][7:0] duty_sh;
  logic [7:0]      top_sh;
  logic [7:0]      presc_sh;
  logic [7:0]      ctrl;
  logic [3:0][7:0] duty_a;
  logic [7:0]      top_a;
  logic [7:0]      presc_a;
  logic [7:0]      pc;
  logic [7:0]      cnt;
  logic            run;
  logic            inv;
  logic            tick;
  logic            wrap;
  logic            wrap_d;
  logic            tick_q;
  logic [3:0]      pwm_q;
  logic            unused_ok;

  assign run  = ctrl[4];
  assign inv  = ctrl[5];
  assign we   = stb_q[1] & ~stb_q[2];
  assign tick = run & (pc == presc_a);
  assign wrap = tick & (cnt == top_a);

  assign uo_out    = {2'b00, run, tick_q, pwm_q};
  assign uio_out   = 8'h00;
  assign uio_oe    = 8'h00;
  assign unused_ok = ^{ena, uio_in[6:3], ctrl[7:6]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_q <= '0;
    end else begin
      stb_q <= {stb_q[1:0], uio_in[7]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh  <= '0;
      top_sh   <= 8'hff;
      presc_sh <= 8'h00;
      ctrl     <= 8'h00;
    end else if (we) begin
      unique case (uio_in[2:0])
        3'd0, 3'd1,
        3'd2, 3'd3: duty_sh[uio_in[1:0]] <= ui_in;
        3'd4:       top_sh   <= ui_in;
        3'd5:       presc_sh <= ui_in;
        3'd6:       ctrl     <= ui_in;
        default:    ;
      endcase
    end
  end

`ifdef PWM_SYNC_LOAD_EN
  // Loading only at wrap keeps every period internally consistent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_a  <= '0;
      top_a   <= 8'hff;
      presc_a <= 8'h00;
    end else if (!run || wrap) begin
      duty_a  <= duty_sh;
      top_a   <= top_sh;
      presc_a <= presc_sh;
    end
  end
`else
  assign duty_a  = duty_sh;
  assign top_a   = top_sh;
  assign presc_a = presc_sh;
`endif

  // cnt above a freshly lowered top runs on through 255 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= '0;
      cnt <= '0;
    end else if (!run) begin
      pc  <= '0;
      cnt <= '0;
    end else if (tick) begin
      pc  <= '0;
      cnt <= wrap ? 8'd0 : cnt + 8'd1;
    end else begin
      pc  <= pc + 8'd1;
    end
  end

  // Tick is delayed twice to line up with the registered cnt==0 output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_d <= 1'b0;
      tick_q <= 1'b0;
      pwm_q  <= '0;
    end else begin
      wrap_d <= wrap;
      tick_q <= wrap_d & run;
      for (int i = 0; i < 4; i++) begin
        pwm_q[i] <= ctrl[i] & run & ((cnt < duty_a[i]) ^ inv);
      end
    end
  end

endmodule

// File: tb/tb_tt_um_ziyi_yuchen.sv
// Self-checking bench for tt_um_ziyi_yuchen: table-driven PWM windows
// plus reset, stop and mid-period duty update sequences.
module tb_tt_um_ziyi_yuchen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0]      top;
    logic [7:0]      presc;
    logic [3:0][7:0] duty;
    logic [7:0]      ctrl;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] sb_q [$];

  tt_um_ziyi_yuchen dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    ui_in  = d;
    uio_in = {1'b1, 4'b0000, a};
    repeat (3) @(negedge clk);
    uio_in[7] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_tick(input int budget);
    int k;
    k = 0;
    while (!uo_out[4] && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (!uo_out[4]) begin
      n_fail++;
      $display("FAIL wait_tick: got timeout expected tick");
    end
  endtask

  function automatic logic [7:0] model(input vec_t v, input int i);
    int         per;
    int         c;
    logic [3:0] p;
    per = (v.top + 1) * (v.presc + 1);
    c   = (i / (v.presc + 1)) % (v.top + 1);
    for (int n = 0; n < 4; n++)
      p[n] = v.ctrl[n] & v.ctrl[4] & ((c < v.duty[n]) ^ v.ctrl[5]);
    return {2'b00, v.ctrl[4], ((i % per) == 0), p};
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int per;
    per = (v.top + 1) * (v.presc + 1);
    wr(3'd6, 8'h00);
    wr(3'd4, v.top);
    wr(3'd5, v.presc);
    for (int n = 0; n < 4; n++) wr(n[2:0], v.duty[n]);
    wr(3'd7, 8'hff);
    wr(3'd6, v.ctrl);
    for (int i = 0; i < 2 * per; i++) sb_q.push_back(model(v, i));
    wait_tick(4000);
    for (int i = 0; i < 2 * per; i++) begin
      if (i > 0) @(negedge clk);
      chk(nm, uo_out, sb_q.pop_front());
    end
  endtask

  initial begin
    int   hi;
    vec_t d;
    vecs[0] = '{8'd3, 8'd0, {8'd0, 8'd0, 8'd0, 8'd2}, 8'h11};
    vecs[1] = '{8'd3, 8'd1, {8'd0, 8'd0, 8'd0, 8'd2}, 8'h11};
    vecs[2] = '{8'd3, 8'd0, {8'd0, 8'd5, 8'd0, 8'd0}, 8'h16};
    vecs[3] = '{8'd7, 8'd2, {8'd255, 8'd0, 8'd8, 8'd3}, 8'h1f};
    vecs[4] = '{8'd5, 8'd0, {8'd1, 8'd6, 8'd0, 8'd3}, 8'h3f};
    vecs[5] = '{8'd3, 8'd0, {8'd0, 8'd0, 8'd0, 8'd1}, 8'h31};

    #2;
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_oe", uio_oe, 8'h00);
    chk("rst_uio", uio_out, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle", uo_out, 8'h00);

    run_vec(vecs[0], "top3_d2");
    run_vec(vecs[1], "presc1");
    run_vec(vecs[2], "d0_dbig");
    run_vec(vecs[3], "mixed");
    run_vec(vecs[4], "inv_all");
    run_vec(vecs[5], "inv_d1");

    wr(3'd6, 8'h21);
    for (int i = 0; i < 12; i++) begin
      chk("stop", uo_out, 8'h00);
      @(negedge clk);
    end

    wr(3'd4, 8'd15);
    wr(3'd5, 8'd0);
    wr(3'd0, 8'd4);
    wr(3'd6, 8'h11);
    wait_tick(200);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        ui_in  = 8'd12;
        uio_in = 8'h80;
      end
      if (i == 3) uio_in = 8'h00;
      hi += int'(uo_out[0]);
      @(negedge clk);
    end
`ifdef PWM_SYNC_LOAD_EN
    chk("upd_cur", 8'(hi), 8'd4);
`else
    chk("upd_cur", 8'(hi), 8'd12);
`endif
    chk("upd_tick", {7'd0, uo_out[4]}, 8'd1);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      hi += int'(uo_out[0]);
      @(negedge clk);
    end
    chk("upd_next", 8'(hi), 8'd12);

    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_uo", uo_out, 8'h00);
    chk("midrst_oe", uio_oe, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("postrst", uo_out, 8'h00);
    d = '{8'd255, 8'd0, {8'd0, 8'd0, 8'd0, 8'd128}, 8'h11};
    wr(3'd0, 8'd128);
    wr(3'd6, 8'h11);
    for (int i = 0; i < 256; i++) sb_q.push_back(model(d, i));
    wait_tick(600);
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      chk("dflt_top", uo_out, sb_q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
